// File: rtl/debug_display_seq.sv
// debug_display_seq
// Routes one of N_CH packed 7-segment channel words to the front-panel digits
// through a registered output. Supports manual one-hot selection, auto-scroll
// with a programmable dwell time, a push-button channel step, and a
// freeze/hold capture of the displayed value.
// Optional build macro: DEBUG_DISPLAY_BLINK_EN blinks the held word while frozen.
module debug_display_seq #(
    parameter int N_CH       = 8,
    parameter int DIGITS     = 2,
    parameter int DWELL      = 50_000_000,
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_CH*DIGITS*8-1:0]    SEG_BUS,
    input  logic [N_CH-1:0]             SEL,
    input  logic                        MODE,
    input  logic                        BTN_NEXT,
    input  logic                        FREEZE,
    output logic [DIGITS*8-1:0]         SEG,
    output logic [$clog2(N_CH)-1:0]     CH_IDX,
    output logic                        CH_VALID,
    output logic                        FROZEN
);

    localparam int W     = DIGITS * 8;
    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(DWELL);

    localparam logic [W-1:0]     DASHES     = {DIGITS{8'b1011_1111}};
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    // Reject parameter sets the datapath widths cannot represent.
    if (N_CH < 2 || N_CH > 16 || DIGITS < 1 || DWELL < 2 || BLINK_HALF < 1) begin : g_param_check
        $error("debug_display_seq: illegal parameter set");
    end

    typedef enum logic {
        ST_LIVE,
        ST_HELD
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      word_q, word_d;
    logic [IDX_W-1:0]  ch_idx_q, ch_idx_d;
    logic              ch_valid_q, ch_valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              btn_q;

    logic              sel_one;
    logic [IDX_W-1:0]  sel_idx;
    logic              hold;
    logic              entering;
    logic              btn_edge;
    logic              tick;
    logic [IDX_W-1:0]  eff_idx;
    logic [IDX_W-1:0]  next_idx;

    assign sel_one = $onehot(SEL);

    // Position of the set bit in SEL; only meaningful when SEL is one-hot.
    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (SEL[k]) begin
                sel_idx = IDX_W'(k);
            end
        end
    end

    // Next-state logic: live channel selection, scroll stepping and hold.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d    = FREEZE ? ST_HELD : ST_LIVE;
        word_d     = word_q;
        ch_idx_d   = ch_idx_q;
        ch_valid_d = ch_valid_q;
        idx_d      = idx_q;
        cnt_d      = '0;
        mode_d     = mode_q;

        // Held once the capture edge has passed and FREEZE is still high.
        hold     = FREEZE && (state_q == ST_HELD);
        // mode_q only follows MODE on live edges, so a mode change made while
        // frozen is still seen as an entry into auto mode on release.
        entering = MODE && !mode_q;
        eff_idx  = entering ? (ch_valid_q ? ch_idx_q : '0) : idx_q;
        next_idx = (eff_idx == LAST_IDX) ? '0 : eff_idx + 1'b1;
        btn_edge = BTN_NEXT && !btn_q;
        tick     = (cnt_q == DWELL_LAST);

        if (!hold) begin
            mode_d = MODE;
            idx_d  = eff_idx;
            if (MODE) begin
                word_d     = SEG_BUS[eff_idx*W +: W];
                ch_idx_d   = eff_idx;
                ch_valid_d = 1'b1;
                // On the capture edge the output is still live but the
                // scroll position stays put, so release resumes from it.
                if (!FREEZE) begin
                    if (tick || btn_edge) begin
                        idx_d = next_idx;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end else if (sel_one) begin
                word_d     = SEG_BUS[sel_idx*W +: W];
                ch_idx_d   = sel_idx;
                ch_valid_d = 1'b1;
            end else begin
                word_d     = DASHES;
                ch_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (RST) begin
            state_q    <= ST_LIVE;
            word_q     <= DASHES;
            ch_idx_q   <= '0;
            ch_valid_q <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            btn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            ch_idx_q   <= ch_idx_d;
            ch_valid_q <= ch_valid_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            btn_q      <= BTN_NEXT;
        end
    end

    assign CH_IDX   = ch_idx_q;
    assign CH_VALID = ch_valid_q;
    assign FROZEN   = (state_q == ST_HELD);

`ifdef DEBUG_DISPLAY_BLINK_EN
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_HALF - 1);

    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic            phase_q, phase_d;
    logic [W-1:0]    seg_q, seg_d;

    // Blink phase: restarts "on" at capture and on release, toggles every
    // BLINK_HALF held cycles; the "off" phase blanks all segments.
    always_comb begin
        bl_cnt_d = '0;
        phase_d  = 1'b1;
        if (hold) begin
            phase_d = phase_q;
            if (bl_cnt_q == BLINK_LAST) begin
                phase_d = !phase_q;
            end else begin
                bl_cnt_d = bl_cnt_q + 1'b1;
            end
        end
        seg_d = phase_d ? word_d : '1;
    end

    // Blink counter and registered (possibly blanked) segment output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bl_cnt_q <= '0;
            phase_q  <= 1'b1;
            seg_q    <= DASHES;
        end else begin
            bl_cnt_q <= bl_cnt_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
        end
    end

    assign SEG = seg_q;
`else
    assign SEG = word_q;
`endif

endmodule
